// File: rtl/multi_filter_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : multi_filter_pkg
//  Brief   : Shared defaults and types for the multi-channel debounce filter
//  Revision: 1.0  initial release
// ============================================================================
package multi_filter_pkg;

  // Default build of the filter; the bench reuses these so both agree.
  localparam int  N_CH_DEF        = 4;
  localparam int  CNT_W_DEF       = 4;
  localparam int  SYNC_STAGES_DEF = 2;
  localparam logic RESET_VAL_DEF  = 1'b0;

  // Outcome of one filter decision for a channel.
  typedef enum logic [1:0] {
    EDGE_NONE = 2'd0,
    EDGE_RISE = 2'd1,
    EDGE_FALL = 2'd2
  } edge_e;

  // Classify a committed level change into the pulse it produces.
  function automatic edge_e edge_of(input logic new_level);
    return new_level ? EDGE_RISE : EDGE_FALL;
  endfunction

endpackage : multi_filter_pkg
`default_nettype wire

// File: rtl/multi_filter_chan.sv
`default_nettype none
// ============================================================================
//  Module  : multi_filter_chan
//  Brief   : One debounce channel: synchroniser, stability counter, filtered
//            level and one-cycle rise/fall pulses
//  Revision: 1.0  initial release
// ============================================================================
module multi_filter_chan
  import multi_filter_pkg::*;
#(
  parameter int   CNT_W       = CNT_W_DEF,
  parameter int   SYNC_STAGES = SYNC_STAGES_DEF,  // must be >= 2
  parameter logic RESET_VAL   = RESET_VAL_DEF
) (
  input  logic             clock,
  input  logic             reset,    // asynchronous, active low
  input  logic             en,
  input  logic [CNT_W-1:0] thr,
  input  logic             sig_in,
  output logic             sig_out,
  output logic             rise,
  output logic             fall
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   out_q, out_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   s;
  edge_e                  edge_kind;

  // Synchroniser keeps shifting regardless of en so it never goes stale.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], sig_in};
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Stability counter and level decision; pulses default low every cycle.
  always_comb begin
    cnt_d     = cnt_q;
    out_d     = out_q;
    edge_kind = EDGE_NONE;
    if (en) begin
      if (s == out_q) begin
        // Any return to the committed level discards the partial run.
        cnt_d = '0;
      end else if (cnt_q >= thr) begin
        // cnt may exceed thr if thr was lowered mid-run; flip immediately.
        out_d     = s;
        cnt_d     = '0;
        edge_kind = edge_of(s);
      end else begin
        // cnt < thr here, so the increment can never wrap.
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    rise_d = (edge_kind == EDGE_RISE);
    fall_d = (edge_kind == EDGE_FALL);
  end

  // State registers; reset lands on RESET_VAL so no pulse follows release.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      cnt_q  <= '0;
      out_q  <= RESET_VAL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      out_q  <= out_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign sig_out = out_q;
  assign rise    = rise_q;
  assign fall    = fall_q;

endmodule : multi_filter_chan
`default_nettype wire

// File: rtl/multi_filter.sv
`default_nettype none
// ============================================================================
//  Module  : multi_filter
//  Brief   : N_CH independent debounce channels sharing enable and threshold,
//            with a combined any-edge indication
//  Revision: 1.0  initial release
// ============================================================================
module multi_filter
  import multi_filter_pkg::*;
#(
  parameter int   N_CH        = N_CH_DEF,
  parameter int   CNT_W       = CNT_W_DEF,
  parameter int   SYNC_STAGES = SYNC_STAGES_DEF,
  parameter logic RESET_VAL   = RESET_VAL_DEF
) (
  input  logic             clock,
  input  logic             reset,    // asynchronous, active low
  input  logic             en,
  input  logic [CNT_W-1:0] thr,
  input  logic [N_CH-1:0]  sig_in,
  output logic [N_CH-1:0]  sig_out,
  output logic [N_CH-1:0]  rise,
  output logic [N_CH-1:0]  fall,
  output logic             any_edge
);

  // One self-contained filter per input pin.
  for (genvar i = 0; i < N_CH; i++) begin : g_chan
    multi_filter_chan #(
      .CNT_W       (CNT_W),
      .SYNC_STAGES (SYNC_STAGES),
      .RESET_VAL   (RESET_VAL)
    ) u_chan (
      .clock   (clock),
      .reset   (reset),
      .en      (en),
      .thr     (thr),
      .sig_in  (sig_in[i]),
      .sig_out (sig_out[i]),
      .rise    (rise[i]),
      .fall    (fall[i])
    );
  end

  // Pulses are already registered, so this OR adds no extra latency.
  assign any_edge = |(rise | fall);

endmodule : multi_filter
`default_nettype wire

// File: tb/tb_multi_filter.sv
`default_nettype none
// ============================================================================
//  Module  : tb_multi_filter
//  Brief   : Self-checking bench for multi_filter (directed steps plus a
//            random phase against a cycle model feeding a scoreboard)
//  Revision: 1.0  initial release
// ============================================================================
module tb_multi_filter;
  import multi_filter_pkg::*;

  localparam int   N  = N_CH_DEF;
  localparam int   CW = CNT_W_DEF;
  localparam int   SS = SYNC_STAGES_DEF;
  localparam logic RV = RESET_VAL_DEF;

  logic          clock  = 1'b0;
  logic          reset  = 1'b0;
  logic          en     = 1'b0;
  logic [CW-1:0] thr    = '0;
  logic [N-1:0]  sig_in = '0;
  logic [N-1:0]  sig_out, rise, fall;
  logic          any_edge;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [N-1:0] out;
    logic [N-1:0] rise;
    logic [N-1:0] fall;
  } exp_t;

  exp_t sb[$];

  multi_filter #(
    .N_CH        (N),
    .CNT_W       (CW),
    .SYNC_STAGES (SS),
    .RESET_VAL   (RV)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .en       (en),
    .thr      (thr),
    .sig_in   (sig_in),
    .sig_out  (sig_out),
    .rise     (rise),
    .fall     (fall),
    .any_edge (any_edge)
  );

  always #5 clock = ~clock;

  // Reference model: behavioural cycle model, pushes expected outputs per edge.
  logic [SS-1:0][N-1:0] m_sync;
  logic [N-1:0]         m_out, m_rise, m_fall;
  int                   m_cnt [N];

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < SS; k++) m_sync[k] = {N{RV}};
      m_out  = {N{RV}};
      m_rise = '0;
      m_fall = '0;
      for (int c = 0; c < N; c++) m_cnt[c] = 0;
    end else begin
      m_rise = '0;
      m_fall = '0;
      for (int c = 0; c < N; c++) begin
        if (en) begin
          if (m_sync[SS-1][c] == m_out[c]) begin
            m_cnt[c] = 0;
          end else if (m_cnt[c] >= int'(thr)) begin
            m_out[c]  = m_sync[SS-1][c];
            m_cnt[c]  = 0;
            m_rise[c] = m_out[c];
            m_fall[c] = ~m_out[c];
          end else begin
            m_cnt[c] = m_cnt[c] + 1;
          end
        end
      end
      for (int k = SS-1; k > 0; k--) m_sync[k] = m_sync[k-1];
      m_sync[0] = sig_in;
      sb.push_back('{out: m_out, rise: m_rise, fall: m_fall});
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and compare all outputs against reset values or model.
  task automatic step();
    exp_t e;
    @(posedge clock);
    #1;
    if (!reset) begin
      chk("rst_out",  32'(sig_out),  32'({N{RV}}));
      chk("rst_rise", 32'(rise),     32'(0));
      chk("rst_fall", 32'(fall),     32'(0));
      chk("rst_any",  32'(any_edge), 32'(0));
    end else begin
      total++;
      assert (sb.size() != 0) else begin
        bad++;
        $error("FAIL sb_empty observed=%0d expected=%0d", sb.size(), 1);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("sb_out",  32'(sig_out),  32'(e.out));
        chk("sb_rise", 32'(rise),     32'(e.rise));
        chk("sb_fall", 32'(fall),     32'(e.fall));
        chk("sb_any",  32'(any_edge), 32'(|(e.rise | e.fall)));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // 1: reset held with toggling inputs, then release with no pulses
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      sig_in = N'(i * 5);
      step();
    end
    sig_in = '0;
    step();
    reset = 1'b1;
    en    = 1'b1;
    thr   = CW'(3);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rel_no_edge", 32'(any_edge), 32'(0));
    end

    // 2: thr=3, ch0 rises; output after exactly 2+3+1 edges
    sig_in[0] = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step();
      chk("t2_hold", 32'(sig_out[0]), 32'(0));
    end
    step();
    chk("t2_flip", 32'(sig_out[0]), 32'(1));
    chk("t2_rise", 32'(rise[0]),    32'(1));
    step();
    chk("t2_rise_end", 32'(rise[0]), 32'(0));

    // 3: ch1 glitch of 3 clocks is rejected
    sig_in[1] = 1'b1;
    for (int i = 0; i < 3; i++) step();
    sig_in[1] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("t3_out",  32'(sig_out[1]),         32'(0));
      chk("t3_edge", 32'({rise[1], fall[1]}), 32'(0));
    end

    // 4: thr=0 pass-through, 3 clock latency, pulse per edge
    thr = '0;
    sig_in[3] = 1'b1;
    step(); step();
    chk("t4_r_hold", 32'(sig_out[3]), 32'(0));
    step();
    chk("t4_r_flip", 32'(sig_out[3]), 32'(1));
    chk("t4_rise",   32'(rise[3]),    32'(1));
    step();
    chk("t4_rise_end", 32'(rise[3]), 32'(0));
    sig_in[3] = 1'b0;
    step(); step();
    chk("t4_f_hold", 32'(sig_out[3]), 32'(1));
    step();
    chk("t4_f_flip", 32'(sig_out[3]), 32'(0));
    chk("t4_fall",   32'(fall[3]),    32'(1));
    step();

    // 5: en=0 freezes ch2 for 20 clocks; resumes and flips after thr+1
    thr = CW'(3);
    en  = 1'b0;
    sig_in[2] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("t5_frozen", 32'({sig_out[2], rise[2]}), 32'(0));
    end
    en = 1'b1;
    for (int i = 0; i < 3; i++) step();
    chk("t5_pre", 32'(sig_out[2]), 32'(0));
    step();
    chk("t5_flip", 32'(sig_out[2]), 32'(1));
    chk("t5_rise", 32'(rise[2]),    32'(1));

    // 6: reset mid-count (cnt=2, thr=5) discards progress
    step(); step();
    thr = CW'(5);
    sig_in[1] = 1'b1;
    for (int i = 0; i < 4; i++) step();
    reset = 1'b0;
    step(); step();
    reset = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step();
      chk("t6_hold", 32'(sig_out[1]), 32'(0));
    end
    step();
    chk("t6_flip", 32'(sig_out[1]), 32'(1));

    // Random phase on all channels against the model
    for (int i = 0; i < 400; i++) begin
      if (i % 50 == 0) begin
        case ($urandom_range(0, 4))
          0:       thr = CW'(0);
          1:       thr = CW'(1);
          2:       thr = CW'(2);
          3:       thr = CW'(3);
          default: thr = {CW{1'b1}};
        endcase
      end
      en = ($urandom_range(0, 9) != 0);
      for (int c = 0; c < N; c++)
        if ($urandom_range(0, 4) == 0) sig_in[c] = ~sig_in[c];
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_multi_filter
`default_nettype wire
